// File: rtl/alu_pkg.sv
// Operation codes shared by the ALU controller and the execute stage, plus
// a small helper that identifies the branch-compare codes.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_BNE = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_BGE = 4'b0110;
  localparam logic [3:0] OP_BLT = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_BGE);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: arithmetic/logic results, branch conditions and
// detection of unsupported operation codes.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        operation,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [DATA_W-1:0] result,
  output logic              br_taken,
  output logic              illegal_op
);

  logic cond;

  always_comb begin
    result     = '0;
    cond       = 1'b0;
    illegal_op = 1'b0;
    case (operation)
      OP_AND:  result = src_a & src_b;
      OP_SUB:  result = src_a - src_b;
      OP_ADD:  result = src_a + src_b;
      OP_OR:   result = src_a | src_b;
      OP_XOR:  result = src_a ^ src_b;
      OP_BEQ:  cond   = (src_a == src_b);
      OP_BNE:  cond   = (src_a != src_b);
      OP_BLT:  cond   = ($signed(src_a) < $signed(src_b));
      OP_BGE:  cond   = ($signed(src_a) >= $signed(src_b));
      default: illegal_op = 1'b1;
    endcase
    // Branch codes report their condition as a zero-extended result bit.
    if (is_branch(operation)) begin
      result = {{(DATA_W-1){1'b0}}, cond};
    end
    br_taken = cond;
  end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: computes at accept time and buffers results in a
// two-entry FIFO with valid/ready handshakes on both sides and a flush.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        Operation,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALUResult,
  output logic              BrTaken,
  output logic              IllegalOp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] core_result;
  logic              core_br;
  logic              core_ill;

  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic             accept;
  logic             retire;
  logic [DEPTH-1:0] entry_we;

  logic [DATA_W-1:0] result_mem [DEPTH];
  logic              br_mem     [DEPTH];
  logic              ill_mem    [DEPTH];

  alu_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .operation (Operation),
    .src_a     (SrcA),
    .src_b     (SrcB),
    .result    (core_result),
    .br_taken  (core_br),
    .illegal_op(core_ill)
  );

  // Handshake status depends only on registered occupancy.
  assign in_ready  = (count_reg < FULL);
  assign out_valid = (count_reg != '0);
  assign accept    = in_valid && in_ready && !flush;
  assign retire    = out_valid && out_ready && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry_we
      assign entry_we[gi] = accept && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  // Storage needs no reset: contents are only visible while occupied.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_we[i]) begin
        result_mem[i] <= core_result;
        br_mem[i]     <= core_br;
        ill_mem[i]    <= core_ill;
      end
    end
  end

  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (accept) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (retire) rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({accept, retire})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  always_comb begin
    ALUResult = '0;
    BrTaken   = 1'b0;
    IllegalOp = 1'b0;
    if (out_valid) begin
      ALUResult = result_mem[rd_ptr_reg];
      BrTaken   = br_mem[rd_ptr_reg];
      IllegalOp = ill_mem[rd_ptr_reg];
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: vector table streamed through a
// scoreboard queue, plus stall, flush and asynchronous-reset sequences.
module tb_alu_exec_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        BrTaken;
  logic        IllegalOp;

  alu_exec_stage #(
    .DATA_W(32),
    .DEPTH (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Operation(Operation),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ALUResult(ALUResult),
    .BrTaken  (BrTaken),
    .IllegalOp(IllegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        br;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
    logic        ill;
  } vec_t;

  int   checks  = 0;
  int   errors  = 0;
  int   retired = 0;
  exp_t sb[$];
  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check the model, update the scoreboard
  // for what the coming rising edge will do.
  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic eb,
                       input logic ei, input logic ordy, input logic fl);
    int   sz;
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    out_ready = ordy;
    flush     = fl;
    #1;
    sz = sb.size();
    chk("out_valid", out_valid, sz != 0);
    chk("in_ready", in_ready, sz < 2);
    if (sz == 0) begin
      chk("idle_result", ALUResult, 32'd0);
      chk("idle_br", BrTaken, 1'b0);
      chk("idle_ill", IllegalOp, 1'b0);
    end
    if (fl) begin
      sb.delete();
    end else begin
      if (sz != 0 && ordy) begin
        e = sb.pop_front();
        retired++;
        $display("retire %0d: result=%h br=%b ill=%b", retired, ALUResult, BrTaken, IllegalOp);
        chk("result", ALUResult, e.res);
        chk("br_taken", BrTaken, e.br);
        chk("illegal", IllegalOp, e.ill);
      end
      if (v && sz < 2) sb.push_back('{res: er, br: eb, ill: ei});
    end
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    Operation = 4'b0000;
    SrcA      = '0;
    SrcB      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    vecs[0]  = '{4'b0010, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
    vecs[1]  = '{4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b1, 1'b0};
    vecs[2]  = '{4'b0110, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0};
    vecs[3]  = '{4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0};
    vecs[4]  = '{4'b0100, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0, 1'b0};
    vecs[5]  = '{4'b0101, 32'h000000F0, 32'h000000FF, 32'h0000000F, 1'b0, 1'b0};
    vecs[6]  = '{4'b0001, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[7]  = '{4'b0010, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 1'b0};
    vecs[8]  = '{4'b1000, 32'd9,        32'd9,        32'd1,        1'b1, 1'b0};
    vecs[9]  = '{4'b1000, 32'd9,        32'd8,        32'd0,        1'b0, 1'b0};
    vecs[10] = '{4'b0011, 32'd9,        32'd8,        32'd1,        1'b1, 1'b0};
    vecs[11] = '{4'b0011, 32'd7,        32'd7,        32'd0,        1'b0, 1'b0};
    vecs[12] = '{4'b0111, 32'd5,        32'hFFFFFFFD, 32'd0,        1'b0, 1'b0};
    vecs[13] = '{4'b0110, 32'h80000000, 32'h7FFFFFFF, 32'd0,        1'b0, 1'b0};
    vecs[14] = '{4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b1, 1'b0};
    vecs[15] = '{4'b1111, 32'd3,        32'd4,        32'd0,        1'b0, 1'b1};
    vecs[16] = '{4'b1001, 32'd6,        32'd6,        32'd0,        1'b0, 1'b1};

    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Streaming at occupancy 1: every cycle accepts and retires together.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].br, vecs[i].ill,
            1'b1, 1'b0);
    end
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: fill both entries, hold, then drain in order.
    drive(1'b1, 4'b0001, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0101, 32'hF0, 32'hFF, 32'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("hold_result", ALUResult, 32'd7);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush at full occupancy with a simultaneous offered operation.
    drive(1'b1, 4'b0010, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0010, 32'd4, 32'd5, 32'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0010, 32'd100, 32'd1, 32'd101, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    drive(1'b1, 4'b0100, 32'h10, 32'h01, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset mid-cycle with one buffered entry.
    drive(1'b1, 4'b0010, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    @(posedge clk);
    #3;
    chk("pre_rst_valid", out_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_result", ALUResult, 32'd0);
    chk("async_rst_in_ready", in_ready, 1'b1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the operand and result width.
REQ-002 SHALL have parameter DEPTH, default 2, the number of output buffer entries (fixed at 2 for this release).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  an operation is offered.
REQ-006 SHALL have port in_ready  output  1  the stage can accept an operation this cycle.
REQ-007 SHALL have port Operation  input  4  the ALU operation code from the ALU controller.
REQ-008 SHALL have port SrcA  input  DATA_W  operand A.
REQ-009 SHALL have port SrcB  input  DATA_W  operand B.
REQ-010 SHALL have port flush  input  1  discard all buffered and incoming operations.
REQ-011 SHALL have port out_valid  output  1  the head entry is valid.
REQ-012 SHALL have port out_ready  input  1  the consumer takes the head entry.
REQ-013 SHALL have port ALUResult  output  DATA_W  head result.
REQ-014 SHALL have port BrTaken  output  1  head branch condition.
REQ-015 SHALL have port IllegalOp  output  1  head Operation code unsupported.

Function
REQ-016 SHALL decode Operation: 0000 AND; 0001 SUB (A-B); 0010 ADD (A+B, modulo 2^DATA_W); 0100 OR; 0101 XOR; 1000 BEQ (A==B); 0011 BNE (A!=B); 0111 BLT (signed A<B); 0110 BGE (signed A>=B).
REQ-017 SHALL, for branch codes, produce ALUResult = zero-extended condition bit and BrTaken = condition; for non-branch codes BrTaken = 0.
REQ-018 SHALL, for any other code, produce ALUResult = 0, BrTaken = 0, IllegalOp = 1; IllegalOp = 0 otherwise.
REQ-019 SHALL accept an operation when in_valid and in_ready are both high at a rising edge, and compute its result at accept time.
REQ-020 SHALL present an accepted operation on the outputs with out_valid high in the cycle after acceptance when the buffer was empty (latency 1).
REQ-021 SHALL retire the head entry when out_valid and out_ready are both high at a rising edge.
REQ-022 SHALL hold ALUResult, BrTaken and IllegalOp stable while out_valid is high and out_ready is low.
REQ-023 SHALL deliver entries in acceptance order (FIFO) with occupancy 0..2.
REQ-024 SHALL drive in_ready = (occupancy < 2), from registered state only, with no combinational path from out_ready.
REQ-025 SHALL, at occupancy 2 with out_ready high, retire the head and keep in_ready low for that cycle; the next cycle in_ready is high.
REQ-026 SHALL, on a simultaneous accept and retire at occupancy 1, keep occupancy at 1 with the new entry at the head.
REQ-027 SHALL wrap the read and write pointers modulo 2.
REQ-028 SHALL, on flush at a rising edge, empty the buffer and discard any simultaneous accept; flush takes priority over accept and retire.
REQ-029 SHALL drive ALUResult, BrTaken and IllegalOp to 0 whenever out_valid is low.

Reset
REQ-030 SHALL, while reset is high, immediately clear occupancy and pointers and drive out_valid = 0, ALUResult = 0, BrTaken = 0 and IllegalOp = 0, with in_ready = 1 after reset.
REQ-031 SHALL drop any in-flight or buffered operation when reset is asserted mid-operation, and deliver none of it after reset is released.

Structure
REQ-032 SHALL take the Operation code constants (OP_AND, OP_SUB, OP_ADD, OP_OR, OP_XOR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE) from the shared package alu_pkg, which the ALU controller also uses.
REQ-033 SHALL implement the combinational compute of REQ-016..018 in the sub-module alu_core, with buffering and handshake logic in alu_exec_stage.

Verification
REQ-034 Accept ADD with A=5, B=7 into the empty stage, out_ready=1 -> the next cycle out_valid=1, ALUResult=12, BrTaken=0.
REQ-035 BLT with A=0xFFFFFFFF, B=1; then BGE with the same operands -> BrTaken=1, ALUResult=1; then BrTaken=0, ALUResult=0.
REQ-036 out_ready=0, accept SUB(10,3) then XOR(0xF0,0xFF) -> in_ready=0 after the second accept; outputs hold 7; after out_ready=1 the outputs show 7 then 0x0F, in order.
REQ-037 Occupancy 2, assert flush with in_valid=1 -> the next cycle out_valid=0, occupancy 0, in_ready=1; the flushed-cycle input never appears.
REQ-038 Operation=1111 with A=3, B=4 -> IllegalOp=1, ALUResult=0, BrTaken=0.
REQ-039 Assert reset asynchronously mid-cycle with occupancy 1 -> out_valid falls before the next edge; after release no stale entry appears.
